mc_moving_avg: RTL

- Multi-channel, time-multiplexed moving-average filter with valid/ready handshake on input and output.
- Window length is selectable at runtime as a power of two up to 2^LOG2_NMAX.
- Per-channel circular sample history and running sums; optional round-half-up on the divide.
- Sits in the sample datapath after the ADC/channel mux; next-generation replacement for the single-channel fixed-window averager.

---
 rtl/mc_moving_avg.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mc_moving_avg.sv
// mc_moving_avg: multi-channel, time-multiplexed moving-average filter.
// Each channel keeps a circular sample history, a fill count and a running
// sum. The window is 2^L samples, with L selectable at runtime. The result is
// the running sum divided by 2^L, with optional round-half-up.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   in_valid      input handshake: sample valid
//   in_ready      input handshake: block can accept a sample
//   in_ch         channel index of the input sample (in_ch >= CH is dropped)
//   in_sample     signed input sample
//   win_log2      window exponent L (clamped to LOG2_NMAX)
//   clear         synchronous flush of all channels
//   out_valid     output handshake: result valid
//   out_ready     output handshake: downstream accepts the result
//   out_ch        channel of the result
//   out_sample    signed averaged sample
//   out_full      window of out_ch was full when the result was produced
module mc_moving_avg #(
  parameter int WIDTH     = 16,
  parameter int CH        = 4,
  parameter int LOG2_NMAX = 5,
  parameter int DO_ROUND  = 1,
  localparam int CHW      = (CH > 1) ? $clog2(CH) : 1,
  localparam int LW       = $clog2(LOG2_NMAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CHW-1:0]          in_ch,
  input  logic signed [WIDTH-1:0] in_sample,
  input  logic [LW-1:0]           win_log2,
  input  logic                    clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CHW-1:0]          out_ch,
  output logic signed [WIDTH-1:0] out_sample,
  output logic                    out_full
);

  localparam int NMAX = 1 << LOG2_NMAX;
  localparam int PW   = (LOG2_NMAX > 0) ? LOG2_NMAX : 1;
  localparam int CW   = LOG2_NMAX + 1;
  localparam int SW   = WIDTH + LOG2_NMAX;

  logic signed [WIDTH-1:0] r_hist  [CH][NMAX];
  logic [PW-1:0]           r_ptr   [CH];
  logic [CW-1:0]           r_count [CH];
  logic signed [SW-1:0]    r_sum   [CH];
  logic [LW-1:0]           r_win_q;

  logic [LW-1:0]           w_l;
  logic                    w_flush;
  logic [CW-1:0]           w_win;
  logic                    w_ch_ok;
  logic [CHW-1:0]          w_c;
  logic                    w_full_now;
  logic [PW-1:0]           w_old_idx;
  logic signed [WIDTH-1:0] w_old;
  logic signed [SW-1:0]    w_in_ext;
  logic signed [SW-1:0]    w_old_ext;
  logic signed [SW-1:0]    w_new_sum;
  logic [SW-1:0]           w_rnd;
  logic signed [SW-1:0]    w_rsum;
  logic signed [SW-1:0]    w_div;
  logic [CW-1:0]           w_new_count;
  logic                    w_take;

  assign w_l     = (win_log2 > LW'(LOG2_NMAX)) ? LW'(LOG2_NMAX) : win_log2;
  assign w_flush = clear || (w_l != r_win_q);

  assign in_ready = (!out_valid || out_ready) && !w_flush;

  // Outside a flush cycle w_l equals r_win_q, so the registered L is used.
  assign w_win = CW'(1) << r_win_q;

  assign w_ch_ok = {1'b0, in_ch} < (CHW + 1)'(CH);
  assign w_c     = w_ch_ok ? in_ch : '0;
  assign w_take  = in_valid && in_ready && w_ch_ok;

  // The sample leaving the window sits W slots behind the write pointer.
  // With W == N_MAX the subtraction wraps back onto the write slot itself.
  assign w_full_now = (r_count[w_c] == w_win);
  assign w_old_idx  = r_ptr[w_c] - w_win[PW-1:0];
  assign w_old      = w_full_now ? r_hist[w_c][w_old_idx] : '0;

  assign w_in_ext  = {{LOG2_NMAX{in_sample[WIDTH-1]}}, in_sample};
  assign w_old_ext = {{LOG2_NMAX{w_old[WIDTH-1]}}, w_old};
  assign w_new_sum = r_sum[w_c] + w_in_ext - w_old_ext;

  // 2^(L-1) for L>0, and 0 for L=0, because the right shift drops the bit.
  assign w_rnd  = (DO_ROUND != 0) ? ((SW'(1) << r_win_q) >> 1) : '0;
  assign w_rsum = w_new_sum + signed'(w_rnd);
  assign w_div  = w_rsum >>> r_win_q;

  assign w_new_count = w_full_now ? r_count[w_c] : r_count[w_c] + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_q    <= '0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_sample <= '0;
      out_full   <= 1'b0;
      for (int unsigned i = 0; i < CH; i++) begin
        r_ptr[i]   <= '0;
        r_count[i] <= '0;
        r_sum[i]   <= '0;
      end
    end else begin
      if (w_flush) begin
        r_win_q <= w_l;
        for (int unsigned i = 0; i < CH; i++) begin
          r_count[i] <= '0;
          r_sum[i]   <= '0;
        end
      end else if (w_take) begin
        r_sum[w_c]   <= w_new_sum;
        r_ptr[w_c]   <= r_ptr[w_c] + PW'(1);
        r_count[w_c] <= w_new_count;
      end

      // The result register is only overwritten when it is empty or being
      // consumed in the same cycle, which in_ready already guarantees.
      if (w_take) begin
        out_valid  <= 1'b1;
        out_ch     <= in_ch;
        out_sample <= w_div[WIDTH-1:0];
        out_full   <= (w_new_count == w_win);
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

  // The history is left unreset: entries are only read once count shows
  // they have been written since the last flush.
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_hist[w_c][r_ptr[w_c]] <= in_sample;
    end
  end

endmodule
